// File: rtl/axi_up_pkg.sv
// Shared types and the per-word transform for the stream copy engine.
// Holds the mode and state enums and transform_word().
package axi_up_pkg;

    // Widest data word the transform helper supports.
    localparam int UP_MAX_DW = 512;

    typedef enum logic [1:0] {
        MODE_COPY  = 2'd0,
        MODE_SHL1  = 2'd1,
        MODE_INV   = 2'd2,
        MODE_BSWAP = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // The word is zero-extended to UP_MAX_DW; the caller truncates the result
    // back to its word width, which drops the bit shifted out by SHL1 and the
    // inverted padding of INV.
    function automatic logic [UP_MAX_DW-1:0] transform_word(
        input mode_e                  mode,
        input logic [UP_MAX_DW-1:0]   data,
        input int                     nbytes
    );
        logic [UP_MAX_DW-1:0] res;
        res = '0;
        unique case (mode)
            MODE_COPY:  res = data;
            MODE_SHL1:  res = data << 1;
            MODE_INV:   res = ~data;
            MODE_BSWAP: begin
                // Reversing the whole padded vector parks the word's bytes
                // at the top; shift them back down to bit 0.
                res = {<<8{data}};
                res = res >> (UP_MAX_DW - 8 * nbytes);
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/up_sync_fifo.sv
// Synchronous word FIFO with flush; head word is visible on o_data.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_data, i_pop, i_flush, o_data, o_full, o_empty.
module up_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi_up_stream_ctrl.sv
// Word copy engine: reads size_i bytes from src, transforms each word, writes to dst.
// Ports: ACLK/ARESET, APB-side config and cmd pulses, rd/wt req-gnt engines, status and int_o.
module axi_up_stream_ctrl
    import axi_up_pkg::*;
#(
    parameter int  REG_SIZE_WIDTH = 16,
    parameter int  AXI_ADDR_WIDTH = 32,
    parameter int  AXI_DATA_WIDTH = 64,
    parameter int  FIFO_DEPTH     = 4,
    localparam int ADDR_LSB       = $clog2(AXI_DATA_WIDTH / 8)
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0]          src_addr_i,
    input  logic [AXI_ADDR_WIDTH-1:0]          dst_addr_i,
    input  logic [REG_SIZE_WIDTH-1:0]          size_i,
    input  logic [1:0]                         mode_i,
    input  logic                               ctrl_int_en_i,
    input  logic                               cmd_trigger_pulse_i,
    input  logic                               cmd_abort_pulse_i,
    input  logic                               cmd_clr_int_pulse_i,
    output logic                               rd_req_o,
    output logic [AXI_ADDR_WIDTH-ADDR_LSB-1:0] rd_word_addr_o,
    input  logic [AXI_DATA_WIDTH-1:0]          rd_data_i,
    input  logic                               rd_gnt_i,
    output logic                               wt_req_o,
    output logic [AXI_ADDR_WIDTH-ADDR_LSB-1:0] wt_word_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]          wt_data_o,
    input  logic                               wt_gnt_i,
    output logic                               status_busy_o,
    output logic                               status_int_pending_o,
    output logic                               status_aborted_o,
    output logic [REG_SIZE_WIDTH-ADDR_LSB-1:0] status_words_done_o,
    output logic                               int_o
);
    localparam int WORD_BYTES = AXI_DATA_WIDTH / 8;
    localparam int WAW        = AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int CW         = REG_SIZE_WIDTH - ADDR_LSB;

    state_e                    r_state;
    mode_e                     r_mode;
    logic [WAW-1:0]            r_rd_addr;
    logic [WAW-1:0]            r_wt_addr;
    logic [CW-1:0]             r_rd_rem;
    logic [CW-1:0]             r_words_done;
    logic                      r_aborted;
    logic                      r_int_pending;
    logic                      r_rd_hold;
    logic                      r_wt_hold;

    logic                      w_rd_req;
    logic                      w_wt_req;
    logic                      w_rd_fire;
    logic                      w_wt_fire;
    logic                      w_push;
    logic                      w_flush;
    logic                      w_full;
    logic                      w_empty;
    logic [AXI_DATA_WIDTH-1:0] w_head;
    logic [AXI_DATA_WIDTH-1:0] w_push_data;
    logic                      w_unused;

    // Sub-word address and size bits carry no information.
    assign w_unused = ^{src_addr_i[ADDR_LSB-1:0],
                        dst_addr_i[ADDR_LSB-1:0],
                        size_i[ADDR_LSB-1:0]};

    // In RUN neither request can drop before its grant: rd_rem and FIFO
    // fullness only move on a read grant. FLUSH only carries over the
    // requests that were pending when the abort was taken.
    always_comb begin
        w_rd_req = 1'b0;
        w_wt_req = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                w_rd_req = (r_rd_rem != '0) & ~w_full;
                w_wt_req = ~w_empty;
            end
            ST_FLUSH: begin
                w_rd_req = r_rd_hold;
                w_wt_req = r_wt_hold;
            end
            default: ;
        endcase
    end

    assign w_rd_fire   = w_rd_req & rd_gnt_i;
    assign w_wt_fire   = w_wt_req & wt_gnt_i;
    assign w_push      = w_rd_fire & (r_state == ST_RUN);
    assign w_flush     = (r_state == ST_FLUSH)
                       & ~(r_rd_hold & ~rd_gnt_i)
                       & ~(r_wt_hold & ~wt_gnt_i);
    assign w_push_data = AXI_DATA_WIDTH'(transform_word(
                             r_mode, UP_MAX_DW'(rd_data_i), WORD_BYTES));

    up_sync_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_wt_fire),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_COPY;
            r_rd_addr     <= '0;
            r_wt_addr     <= '0;
            r_rd_rem      <= '0;
            r_words_done  <= '0;
            r_aborted     <= 1'b0;
            r_int_pending <= 1'b0;
            r_rd_hold     <= 1'b0;
            r_wt_hold     <= 1'b0;
        end else begin
            if (w_push) begin
                r_rd_addr <= r_rd_addr + WAW'(1);
                r_rd_rem  <= r_rd_rem - CW'(1);
            end
            if (w_wt_fire) begin
                r_wt_addr    <= r_wt_addr + WAW'(1);
                r_words_done <= r_words_done + CW'(1);
            end
            if (r_state == ST_DONE) begin
                r_int_pending <= 1'b1;
            end else if (cmd_clr_int_pulse_i) begin
                r_int_pending <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd_trigger_pulse_i) begin
                        r_rd_addr    <= src_addr_i[AXI_ADDR_WIDTH-1:ADDR_LSB];
                        r_wt_addr    <= dst_addr_i[AXI_ADDR_WIDTH-1:ADDR_LSB];
                        r_rd_rem     <= size_i[REG_SIZE_WIDTH-1:ADDR_LSB];
                        r_mode       <= mode_e'(mode_i);
                        r_words_done <= '0;
                        r_aborted    <= 1'b0;
                        r_state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cmd_abort_pulse_i) begin
                        r_rd_hold <= w_rd_req & ~rd_gnt_i;
                        r_wt_hold <= w_wt_req & ~wt_gnt_i;
                        r_state   <= ST_FLUSH;
                    end else if ((r_rd_rem == '0) && w_empty) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_FLUSH: begin
                    r_rd_hold <= r_rd_hold & ~rd_gnt_i;
                    r_wt_hold <= r_wt_hold & ~wt_gnt_i;
                    if (w_flush) begin
                        r_aborted <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_req_o             = w_rd_req;
    assign rd_word_addr_o       = r_rd_addr;
    assign wt_req_o             = w_wt_req;
    assign wt_word_addr_o       = r_wt_addr;
    // FIFO storage is not reset; keep the bus quiet when nothing is offered.
    assign wt_data_o            = w_wt_req ? w_head : '0;
    assign status_busy_o        = (r_state != ST_IDLE);
    assign status_int_pending_o = r_int_pending;
    assign status_aborted_o     = r_aborted;
    assign status_words_done_o  = r_words_done;
    assign int_o                = ctrl_int_en_i & r_int_pending;

endmodule

// File: tb/tb_axi_up_stream_ctrl.sv
// Self-checking bench for axi_up_stream_ctrl (64-bit words, FIFO depth 4).
// Source memory is a fixed hash of the word address; writes are checked against it.
module tb_axi_up_stream_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] size_i = '0;
    logic [1:0]  mode_i = '0;
    logic        ctrl_int_en_i = 1'b1;
    logic        cmd_trigger_pulse_i = 1'b0;
    logic        cmd_abort_pulse_i = 1'b0;
    logic        cmd_clr_int_pulse_i = 1'b0;
    logic        rd_req_o;
    logic [28:0] rd_word_addr_o;
    logic [63:0] rd_data_i = '0;
    logic        rd_gnt_i = 1'b0;
    logic        wt_req_o;
    logic [28:0] wt_word_addr_o;
    logic [63:0] wt_data_o;
    logic        wt_gnt_i = 1'b0;
    logic        status_busy_o;
    logic        status_int_pending_o;
    logic        status_aborted_o;
    logic [12:0] status_words_done_o;
    logic        int_o;

    axi_up_stream_ctrl #(
        .REG_SIZE_WIDTH (16),
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (64),
        .FIFO_DEPTH     (4)
    ) dut (
        .ACLK                 (ACLK),
        .ARESET               (ARESET),
        .src_addr_i           (src_addr_i),
        .dst_addr_i           (dst_addr_i),
        .size_i               (size_i),
        .mode_i               (mode_i),
        .ctrl_int_en_i        (ctrl_int_en_i),
        .cmd_trigger_pulse_i  (cmd_trigger_pulse_i),
        .cmd_abort_pulse_i    (cmd_abort_pulse_i),
        .cmd_clr_int_pulse_i  (cmd_clr_int_pulse_i),
        .rd_req_o             (rd_req_o),
        .rd_word_addr_o       (rd_word_addr_o),
        .rd_data_i            (rd_data_i),
        .rd_gnt_i             (rd_gnt_i),
        .wt_req_o             (wt_req_o),
        .wt_word_addr_o       (wt_word_addr_o),
        .wt_data_o            (wt_data_o),
        .wt_gnt_i             (wt_gnt_i),
        .status_busy_o        (status_busy_o),
        .status_int_pending_o (status_int_pending_o),
        .status_aborted_o     (status_aborted_o),
        .status_words_done_o  (status_words_done_o),
        .int_o                (int_o)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_prob = 100;
    int wt_prob = 100;
    int rd_cnt = 0;
    int stab_viol = 0;
    logic [28:0] wa_q[$];
    logic [63:0] wd_q[$];
    int          wc_q[$];
    bit          prev_rd = 0;
    bit          prev_wt = 0;
    logic [28:0] p_ra;
    logic [28:0] p_wa;
    logic [63:0] p_wd;
    bit          ovr_en = 0;
    logic [28:0] ovr_a = '0;
    logic [63:0] ovr_d = '0;

    function automatic logic [63:0] src_word(input logic [28:0] a);
        if (ovr_en && a == ovr_a) return ovr_d;
        return {3'b101, a, 3'b010, ~a};
    endfunction

    function automatic logic [63:0] xf(input logic [1:0] m, input logic [63:0] d);
        logic [63:0] r;
        case (m)
            2'd0: r = d;
            2'd1: r = d * 64'd2;
            2'd2: r = 64'hFFFF_FFFF_FFFF_FFFF ^ d;
            default: for (int b = 0; b < 8; b++) r[b*8 +: 8] = d[(7-b)*8 +: 8];
        endcase
        return r;
    endfunction

    // Responder: picks this cycle's grants, presents read data for the current
    // address, then logs the handshakes that the next rising edge completes.
    always @(negedge ACLK) begin
        cyc++;
        rd_gnt_i  = ($urandom_range(99) < rd_prob);
        wt_gnt_i  = ($urandom_range(99) < wt_prob);
        rd_data_i = src_word(rd_word_addr_o);
        if (ARESET) begin
            prev_rd = 0;
            prev_wt = 0;
        end else begin
            if (prev_rd && (!rd_req_o || rd_word_addr_o !== p_ra)) stab_viol++;
            if (prev_wt && (!wt_req_o || wt_word_addr_o !== p_wa || wt_data_o !== p_wd)) stab_viol++;
            if (rd_req_o && rd_gnt_i) rd_cnt++;
            if (wt_req_o && wt_gnt_i) begin
                wa_q.push_back(wt_word_addr_o);
                wd_q.push_back(wt_data_o);
                wc_q.push_back(cyc);
            end
            prev_rd = rd_req_o && !rd_gnt_i;
            prev_wt = wt_req_o && !wt_gnt_i;
            p_ra = rd_word_addr_o;
            p_wa = wt_word_addr_o;
            p_wd = wt_data_o;
        end
    end

    task automatic do_trigger(input logic [31:0] s, input logic [31:0] d,
                              input logic [15:0] sz, input logic [1:0] m);
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        rd_cnt = 0;
        @(negedge ACLK);
        src_addr_i = s;
        dst_addr_i = d;
        size_i = sz;
        mode_i = m;
        cmd_trigger_pulse_i = 1'b1;
        @(negedge ACLK);
        cmd_trigger_pulse_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (status_busy_o && n < budget);
        checks++;
        if (status_busy_o) begin
            failures++;
            $display("FAIL %s_timeout busy after %0d cycles, want idle", tag, n);
            ARESET = 1'b1;
            repeat (2) @(negedge ACLK);
            ARESET = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge ACLK);
        cmd_clr_int_pulse_i = 1'b1;
        @(negedge ACLK);
        cmd_clr_int_pulse_i = 1'b0;
    endtask

    task automatic run_vs_model(input string tag, input logic [31:0] s, input logic [31:0] d,
                                input logic [15:0] sz, input logic [1:0] m);
        int nw = int'(sz >> 3);
        logic [28:0] ea;
        logic [63:0] ed;
        do_trigger(s, d, sz, m);
        mode_i = ~m;
        wait_idle(4000, tag);
        checks++;
        if (wa_q.size() != nw) begin
            failures++;
            $display("FAIL %s_count got=%0d want=%0d", tag, wa_q.size(), nw);
        end
        for (int k = 0; k < nw && k < wa_q.size(); k++) begin
            ea = d[31:3] + 29'(k);
            ed = xf(m, src_word(s[31:3] + 29'(k)));
            checks++;
            if (wa_q[k] !== ea || wd_q[k] !== ed) begin
                failures++;
                $display("FAIL %s_word%0d got=%h/%h want=%h/%h", tag, k, wa_q[k], wd_q[k], ea, ed);
            end
        end
        checks++;
        if (status_words_done_o !== 13'(nw) || status_aborted_o !== 1'b0
            || status_int_pending_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_status got done=%0d ab=%b pend=%b want done=%0d ab=0 pend=1",
                     tag, status_words_done_o, status_aborted_o, status_int_pending_o, nw);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ACLK);
        checks++;
        if ({rd_req_o, wt_req_o, status_busy_o, status_int_pending_o, status_aborted_o, int_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000",
                     {rd_req_o, wt_req_o, status_busy_o, status_int_pending_o, status_aborted_o, int_o});
        end
        checks++;
        if (rd_word_addr_o !== '0 || wt_word_addr_o !== '0) begin
            failures++;
            $display("FAIL reset_addr got=%h/%h want=0/0", rd_word_addr_o, wt_word_addr_o);
        end
        checks++;
        if (wt_data_o !== '0 || status_words_done_o !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%0d want=0/0", wt_data_o, status_words_done_o);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if (status_busy_o !== 1'b0 || rd_req_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got busy=%b rdreq=%b want 0/0", status_busy_o, rd_req_o);
        end
    endtask

    task automatic test_copy();
        rd_prob = 100;
        wt_prob = 100;
        ctrl_int_en_i = 1'b1;
        run_vs_model("copy", 32'h1000, 32'h2000, 16'd32, 2'd0);
        checks++;
        if (wa_q.size() != 4 || wa_q[0] !== 29'h400 || wa_q[3] !== 29'h403) begin
            failures++;
            $display("FAIL copy_addrs got n=%0d first=%h last=%h want 4/400/403",
                     wa_q.size(), wa_q[0], wa_q[3]);
        end
        checks++;
        if (wc_q.size() != 4 || wc_q[3] - wc_q[0] != 3) begin
            failures++;
            $display("FAIL copy_b2b got span=%0d want=3", wc_q[3] - wc_q[0]);
        end
        checks++;
        if (int_o !== 1'b1) begin
            failures++;
            $display("FAIL copy_int got=%b want=1", int_o);
        end
    endtask

    task automatic test_modes();
        ovr_en = 1;
        ovr_a = 29'h1234;
        ovr_d = 64'h8000_0000_0000_0001;
        run_vs_model("shl1", {ovr_a, 3'b0}, 32'h3000, 16'd8, 2'd1);
        checks++;
        if (wd_q[0] !== 64'h0000_0000_0000_0002) begin
            failures++;
            $display("FAIL shl1_const got=%h want=0000000000000002", wd_q[0]);
        end
        ovr_d = 64'h0102_0304_0506_0708;
        run_vs_model("bswap", {ovr_a, 3'b0}, 32'h3100, 16'd8, 2'd3);
        checks++;
        if (wd_q[0] !== 64'h0807_0605_0403_0201) begin
            failures++;
            $display("FAIL bswap_const got=%h want=0807060504030201", wd_q[0]);
        end
        run_vs_model("inv", {ovr_a, 3'b0}, 32'h3200, 16'd16, 2'd2);
        ovr_en = 0;
    endtask

    task automatic test_backpressure();
        rd_prob = 100;
        wt_prob = 0;
        do_trigger(32'h4000, 32'h5000, 16'd64, 2'd0);
        repeat (10) @(negedge ACLK);
        checks++;
        if (rd_cnt != 4 || rd_req_o !== 1'b0 || wt_req_o !== 1'b1 || wa_q.size() != 0) begin
            failures++;
            $display("FAIL bp_stall got rd=%0d rdreq=%b wtreq=%b wr=%0d want 4/0/1/0",
                     rd_cnt, rd_req_o, wt_req_o, wa_q.size());
        end
        wt_prob = 100;
        wait_idle(200, "bp");
        checks++;
        if (wa_q.size() != 8) begin
            failures++;
            $display("FAIL bp_count got=%0d want=8", wa_q.size());
        end
        for (int k = 0; k < 8 && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== 29'h0A00 + 29'(k) || wd_q[k] !== src_word(29'h0800 + 29'(k))) begin
                failures++;
                $display("FAIL bp_word%0d got=%h/%h want=%h/%h", k, wa_q[k], wd_q[k],
                         29'h0A00 + 29'(k), src_word(29'h0800 + 29'(k)));
            end
        end
        checks++;
        if (stab_viol != 0) begin
            failures++;
            $display("FAIL bp_stable got=%0d unstable cycles want=0", stab_viol);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        pulse_clr();
        rd_prob = 100;
        wt_prob = 100;
        do_trigger(32'h6000, 32'h7000, 16'd64, 2'd0);
        while (rd_cnt < 2 && n < 50) begin @(posedge ACLK); n++; end
        rd_prob = 0;
        while (wa_q.size() < 2 && n < 50) begin @(posedge ACLK); n++; end
        @(negedge ACLK);
        checks++;
        if (rd_req_o !== 1'b1 || wt_req_o !== 1'b0 || wa_q.size() != 2) begin
            failures++;
            $display("FAIL abort_setup got rdreq=%b wtreq=%b wr=%0d want 1/0/2",
                     rd_req_o, wt_req_o, wa_q.size());
        end
        cmd_abort_pulse_i = 1'b1;
        @(negedge ACLK);
        cmd_abort_pulse_i = 1'b0;
        @(negedge ACLK);
        checks++;
        if (rd_req_o !== 1'b1 || wt_req_o !== 1'b0 || status_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL abort_hold got rdreq=%b wtreq=%b busy=%b want 1/0/1",
                     rd_req_o, wt_req_o, status_busy_o);
        end
        rd_prob = 100;
        wait_idle(50, "abort");
        checks++;
        if (wa_q.size() != 2 || rd_cnt != 3 || wa_q[1] !== 29'h0E01) begin
            failures++;
            $display("FAIL abort_xfers got wr=%0d rd=%0d a1=%h want 2/3/0e01",
                     wa_q.size(), rd_cnt, wa_q[1]);
        end
        checks++;
        if (status_aborted_o !== 1'b1 || status_words_done_o !== 13'd2
            || status_int_pending_o !== 1'b1) begin
            failures++;
            $display("FAIL abort_status got ab=%b done=%0d pend=%b want 1/2/1",
                     status_aborted_o, status_words_done_o, status_int_pending_o);
        end
    endtask

    task automatic test_zero_size();
        pulse_clr();
        do_trigger(32'h8000, 32'h9000, 16'd5, 2'd0);
        checks++;
        if (status_busy_o !== 1'b1 || rd_req_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_c1 got busy=%b rdreq=%b want 1/0", status_busy_o, rd_req_o);
        end
        size_i = 16'd64;
        cmd_trigger_pulse_i = 1'b1;
        @(negedge ACLK);
        cmd_trigger_pulse_i = 1'b0;
        checks++;
        if (status_busy_o !== 1'b1 || status_int_pending_o !== 1'b0 || rd_req_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_c2 got busy=%b pend=%b rdreq=%b want 1/0/0",
                     status_busy_o, status_int_pending_o, rd_req_o);
        end
        @(negedge ACLK);
        checks++;
        if (status_busy_o !== 1'b0 || status_int_pending_o !== 1'b1) begin
            failures++;
            $display("FAIL zero_c3 got busy=%b pend=%b want 0/1", status_busy_o, status_int_pending_o);
        end
        repeat (3) @(negedge ACLK);
        checks++;
        if (rd_cnt != 0 || wa_q.size() != 0 || status_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_noreq got rd=%0d wr=%0d busy=%b want 0/0/0",
                     rd_cnt, wa_q.size(), status_busy_o);
        end
    endtask

    task automatic test_int_clr();
        cmd_clr_int_pulse_i = 1'b1;
        do_trigger(32'hA000, 32'hB000, 16'd8, 2'd0);
        cmd_clr_int_pulse_i = 1'b1;
        wait_idle(50, "clr");
        checks++;
        if (status_int_pending_o !== 1'b1) begin
            failures++;
            $display("FAIL clr_set_wins got=%b want=1", status_int_pending_o);
        end
        cmd_clr_int_pulse_i = 1'b0;
        @(negedge ACLK);
        ctrl_int_en_i = 1'b0;
        #1;
        checks++;
        if (status_int_pending_o !== 1'b1 || int_o !== 1'b0) begin
            failures++;
            $display("FAIL clr_hold got pend=%b int=%b want 1/0", status_int_pending_o, int_o);
        end
        ctrl_int_en_i = 1'b1;
        pulse_clr();
        checks++;
        if (status_int_pending_o !== 1'b0 || int_o !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone got pend=%b int=%b want 0/0", status_int_pending_o, int_o);
        end
    endtask

    task automatic test_midrun_reset();
        wt_prob = 0;
        do_trigger(32'hC000, 32'hD000, 16'd64, 2'd2);
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({status_busy_o, rd_req_o, wt_req_o} !== 3'b0 || status_words_done_o !== '0
            || wt_data_o !== '0 || rd_word_addr_o !== '0) begin
            failures++;
            $display("FAIL midrst got busy=%b rq=%b wq=%b done=%0d data=%h ra=%h want all 0",
                     status_busy_o, rd_req_o, wt_req_o, status_words_done_o, wt_data_o, rd_word_addr_o);
        end
        ARESET = 1'b0;
        wt_prob = 100;
        @(negedge ACLK);
    endtask

    task automatic test_random();
        logic [31:0] s;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            rd_prob = $urandom_range(30, 100);
            wt_prob = $urandom_range(30, 100);
            s = $urandom;
            d = (i % 2 == 1) ? 32'hFFFF_FF00 + ($urandom_range(0, 31) << 3) : $urandom;
            run_vs_model($sformatf("rand%0d", i), s, d, 16'($urandom_range(0, 300)),
                         2'($urandom_range(0, 3)));
        end
        rd_prob = 100;
        wt_prob = 100;
        checks++;
        if (stab_viol != 0) begin
            failures++;
            $display("FAIL rand_stable got=%0d unstable cycles want=0", stab_viol);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_modes();
        test_backpressure();
        test_abort();
        test_zero_size();
        test_int_clr();
        test_midrun_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
